// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the seven-segment display
//                arbiter: segment patterns (bit0 = seg a .. bit6 = seg g,
//                1 = lit), digit geometry and the arbiter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam int BCD_W  = 4;
    localparam int DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Arbiter state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SHOW = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Combinational BCD digit to seven-segment pattern (active
//                high). Codes 10..15 show a dash, i_blank forces all off.
//  Ports       : i_bcd   [3:0] BCD digit
//                i_blank       1 = show nothing
//                o_seg   [6:0] segment pattern, bit0 = seg a
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    input  logic             i_blank,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            if (i_bcd <= 4'd9) begin
                o_seg = SEG_DIGIT[i_bcd];
            end else begin
                o_seg = SEG_DASH;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_arbiter
//  Description : Shares a three-digit seven-segment display between NUM_REQ
//                requesters using round-robin arbitration with a minimum
//                dwell time per grant.
//  Ports       : CLK_50     clock, rising edge
//                RESET      synchronous active-high reset
//                REQ        per-requester display request (level)
//                REQ_VALUE  requester i BCD {hund,tens,units} at [12i+11:12i]
//                GRANT      one-hot current owner (registered)
//                BUSY       1 while a requester owns the display
//                HEX0..HEX2 units/tens/hundreds segment outputs (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int SEG_ACT_LOW  = 0
) (
    input  logic                  CLK_50,
    input  logic                  RESET,
    input  logic [NUM_REQ-1:0]    REQ,
    input  logic [12*NUM_REQ-1:0] REQ_VALUE,
    output logic [NUM_REQ-1:0]    GRANT,
    output logic                  BUSY,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int VAL_W = BCD_W * DIGITS;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [6:0]       c_seg_inv  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

    state_t             r_state_q, w_state_d;
    logic [NUM_REQ-1:0] r_grant_q, w_grant_d;
    logic [IDX_W-1:0]   r_owner_q, w_owner_d;
    logic [IDX_W-1:0]   r_ptr_q,   w_ptr_d;
    logic [CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [VAL_W-1:0]   r_disp_q,  w_disp_d;
    logic               r_blank_q, w_blank_d;
    logic [6:0]         r_hex_q [DIGITS];
    logic [6:0]         w_hex_d [DIGITS];
    logic [6:0]         w_seg   [DIGITS];

    // ------------------------------------------------------------------
    // Round-robin search: first set REQ at or after r_ptr_q, wrapping.
    // The pointer always sits at owner+1, so at dwell expiry the current
    // owner is the last candidate and only wins if nobody else asks.
    // ------------------------------------------------------------------
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W:0]     w_cand;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr_q} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && REQ[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IDX_W-1:0];
            end
        end
    end

    // Owner's request level and value, selected by the registered owner index
    logic             w_owner_req;
    logic [VAL_W-1:0] w_owner_val;

    always_comb begin
        w_owner_req = 1'b0;
        w_owner_val = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_owner_q == IDX_W'(k)) begin
                w_owner_req = REQ[k];
                w_owner_val = REQ_VALUE[12*k +: 12];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM, dwell counter and display register
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_owner_d = r_owner_q;
        w_ptr_d   = r_ptr_q;
        w_cnt_d   = r_cnt_q;
        w_disp_d  = r_disp_q;
        w_blank_d = r_blank_q;

        case (r_state_q)
            ST_IDLE: begin
                w_blank_d = 1'b1;
                if (w_found) begin
                    w_state_d = ST_SHOW;
                    w_grant_d = NUM_REQ'(1) << w_win;
                    w_owner_d = w_win;
                    w_ptr_d   = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    w_cnt_d   = '0;
                end
            end

            ST_SHOW: begin
                // Track the owner's value while it asserts REQ; freeze otherwise.
                if (w_owner_req) begin
                    w_disp_d  = w_owner_val;
                    w_blank_d = 1'b0;
                end

                if (r_cnt_q == c_cnt_last) begin
                    w_cnt_d = '0;
                    if (w_found) begin
                        w_grant_d = NUM_REQ'(1) << w_win;
                        w_owner_d = w_win;
                        w_ptr_d   = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    end else begin
                        w_state_d = ST_IDLE;
                        w_grant_d = '0;
                        w_blank_d = 1'b1;
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_blank_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit decoders; the polarity inversion is applied before the
    // output register so blank reads 7'h7F on active-low boards.
    // ------------------------------------------------------------------
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        seg7_decoder u_dec (
            .i_bcd   (r_disp_q[BCD_W*d +: BCD_W]),
            .i_blank (r_blank_q),
            .o_seg   (w_seg[d])
        );
    end

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            w_hex_d[d] = w_seg[d] ^ c_seg_inv;
        end
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_state_q <= ST_IDLE;
            r_grant_q <= '0;
            r_owner_q <= '0;
            r_ptr_q   <= '0;
            r_cnt_q   <= '0;
            r_disp_q  <= '0;
            r_blank_q <= 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                r_hex_q[d] <= c_seg_inv;
            end
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_owner_q <= w_owner_d;
            r_ptr_q   <= w_ptr_d;
            r_cnt_q   <= w_cnt_d;
            r_disp_q  <= w_disp_d;
            r_blank_q <= w_blank_d;
            for (int d = 0; d < DIGITS; d++) begin
                r_hex_q[d] <= w_hex_d[d];
            end
        end
    end

    assign GRANT = r_grant_q;
    assign BUSY  = (r_state_q == ST_SHOW);
    assign HEX0  = r_hex_q[0];
    assign HEX1  = r_hex_q[1];
    assign HEX2  = r_hex_q[2];

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_arbiter
//  Description : Directed self-checking bench for seg7_display_arbiter with
//                NUM_REQ=2, DWELL_CYCLES=8; a second active-low instance
//                shares the stimulus to check output polarity.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_display_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [23:0] req_value;
    logic [1:0]  grant, grant_al;
    logic        busy, busy_al;
    logic [6:0]  hex0, hex1, hex2;
    logic [6:0]  hex0_al, hex1_al, hex2_al;

    int n_checks = 0;
    int n_errors = 0;

    seg7_display_arbiter #(
        .NUM_REQ      (2),
        .DWELL_CYCLES (8),
        .SEG_ACT_LOW  (0)
    ) dut (
        .CLK_50    (clk),
        .RESET     (rst),
        .REQ       (req),
        .REQ_VALUE (req_value),
        .GRANT     (grant),
        .BUSY      (busy),
        .HEX0      (hex0),
        .HEX1      (hex1),
        .HEX2      (hex2)
    );

    seg7_display_arbiter #(
        .NUM_REQ      (2),
        .DWELL_CYCLES (8),
        .SEG_ACT_LOW  (1)
    ) dut_al (
        .CLK_50    (clk),
        .RESET     (rst),
        .REQ       (req),
        .REQ_VALUE (req_value),
        .GRANT     (grant_al),
        .BUSY      (busy_al),
        .HEX0      (hex0_al),
        .HEX1      (hex1_al),
        .HEX2      (hex2_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
        chk({tag, ".hex2"}, {25'd0, hex2}, {25'd0, h2});
        chk({tag, ".hex1"}, {25'd0, hex1}, {25'd0, h1});
        chk({tag, ".hex0"}, {25'd0, hex0}, {25'd0, h0});
    endtask

    initial begin
        rst       = 1'b1;
        req       = 2'b00;
        req_value = 24'h000_000;

        // 1: reset
        step(2);
        chk("rst.grant", {30'd0, grant}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk_hex("rst", 7'h00, 7'h00, 7'h00);
        chk("rst.al_hex0", {25'd0, hex0_al}, 32'h7F);
        chk("rst.al_hex2", {25'd0, hex2_al}, 32'h7F);
        rst = 1'b0;
        step(1);
        chk("idle.grant", {30'd0, grant}, 32'd0);

        // 2: single request, value 123
        req       = 2'b01;
        req_value = 24'h000_123;
        step(1);
        chk("single.grant", {30'd0, grant}, 32'd1);
        chk("single.busy", {31'd0, busy}, 32'd1);
        step(1);
        chk_hex("single.pre", 7'h00, 7'h00, 7'h00);
        step(1);
        chk_hex("single", 7'h06, 7'h5B, 7'h4F);
        chk("single.al_hex0", {25'd0, hex0_al}, 32'h30);
        step(8);
        chk("single.hold", {30'd0, grant}, 32'd1);

        // 5: invalid BCD while owning
        req_value = 24'h000_A9F;
        step(2);
        chk_hex("badbcd", 7'h40, 7'h6F, 7'h40);

        // owner drops: grant survives until dwell end, display frozen
        req = 2'b00;
        step(3);
        chk("drop1.grant", {30'd0, grant}, 32'd1);
        chk_hex("drop1.frozen", 7'h40, 7'h6F, 7'h40);
        step(1);
        chk("drop1.grant_end", {30'd0, grant}, 32'd0);
        chk("drop1.busy_end", {31'd0, busy}, 32'd0);
        step(1);
        chk_hex("drop1.blank", 7'h00, 7'h00, 7'h00);

        // 4: early drop, REQ0 high for 2 cycles with value 456
        req       = 2'b01;
        req_value = 24'h000_456;
        step(1);
        chk("early.grant", {30'd0, grant}, 32'd1);
        step(1);
        req       = 2'b00;
        req_value = 24'h000_789;
        step(1);
        chk_hex("early.show", 7'h66, 7'h6D, 7'h7D);
        step(5);
        chk("early.hold", {30'd0, grant}, 32'd1);
        chk_hex("early.frozen", 7'h66, 7'h6D, 7'h7D);
        step(1);
        chk("early.idle_grant", {30'd0, grant}, 32'd0);
        chk("early.idle_busy", {31'd0, busy}, 32'd0);
        step(1);
        chk_hex("early.blank", 7'h00, 7'h00, 7'h00);

        // 3: contention from a fresh reset
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        req       = 2'b11;
        req_value = 24'h222_111;
        step(1);
        chk("cont.g0_start", {30'd0, grant}, 32'd1);
        step(7);
        chk("cont.g0_last", {30'd0, grant}, 32'd1);
        step(1);
        chk("cont.g1_start", {30'd0, grant}, 32'd2);
        step(1);
        chk("cont.hex_old", {25'd0, hex0}, 32'h06);
        step(1);
        chk_hex("cont.hex_new", 7'h5B, 7'h5B, 7'h5B);
        step(5);
        chk("cont.g1_last", {30'd0, grant}, 32'd2);
        step(1);
        chk("cont.g0_again", {30'd0, grant}, 32'd1);
        step(8);
        chk("cont.g1_again", {30'd0, grant}, 32'd2);

        // 6: reset at dwell count 4 of requester 1's grant
        step(4);
        chk("midrst.before", {30'd0, grant}, 32'd2);
        rst = 1'b1;
        step(1);
        chk("midrst.grant", {30'd0, grant}, 32'd0);
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk_hex("midrst", 7'h00, 7'h00, 7'h00);
        chk("midrst.al_hex1", {25'd0, hex1_al}, 32'h7F);
        rst = 1'b0;
        step(1);
        chk("midrst.after", {30'd0, grant}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
